// File: rtl/tmr_recovery_ctrl_pkg.sv
// Shared types and constants for the TMR recovery scheduler.
// Core bit map everywhere: [2]=A, [1]=B, [0]=C.
package tmr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HOLD     = 3'd1,
      ST_RESYNC   = 3'd2,
      ST_SYS_HOLD = 3'd3,
      ST_SYS_WAIT = 3'd4
   } state_t;

   localparam int NUM_CORES = 3;
   localparam int CORE_A    = 2;
   localparam int CORE_B    = 1;
   localparam int CORE_C    = 0;

   function automatic logic [2:0] core_onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_debounce.sv
// Per-core persistence filter: counts consecutive unmasked fault cycles,
// saturating at PERSIST; persist is asserted while the count sits at PERSIST.
module tmr_fault_debounce #(
   parameter int PERSIST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flag,
   input  logic mask,
   input  logic clear,
   output logic persist
);

   localparam int CW = $clog2(PERSIST + 1);
   localparam logic [CW-1:0] CNT_TOP = CW'(PERSIST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] cnt;

   // Saturating run-length counter of the raw flag
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (mask || !flag || clear) begin
         cnt <= '0;
      end else if (cnt != CNT_TOP) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

   assign persist = (cnt == CNT_TOP);

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// Recovery scheduler: debounces voter fault flags, then resets/resyncs one
// faulty core at a time, escalating to a system reset on double faults.
module tmr_recovery_ctrl
   import tmr_pkg::*;
#(
   parameter int PERSIST     = 4,
   parameter int RST_HOLD    = 8,
   parameter int RESYNC_WAIT = 16,
   parameter int MAX_RETRY   = 2,
   parameter int CNT_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           fault_flags,
   input  logic                 enable,
   input  logic                 clear_faults,
   output logic [2:0]           core_rst,
   output logic [2:0]           vote_mask,
   output logic                 sys_reset,
   output logic                 recovering,
   output logic [1:0]           recov_core,
   output logic [2:0]           failed,
   output logic                 degraded,
   output logic [3*CNT_W-1:0]   retry_cnt
);

   localparam int PH_MAX = (RST_HOLD > RESYNC_WAIT) ? RST_HOLD : RESYNC_WAIT;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0]  HOLD_LD   = PH_W'(RST_HOLD - 1);
   localparam logic [PH_W-1:0]  WAIT_LD   = PH_W'(RESYNC_WAIT - 1);
   localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
   localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_ONE;
   endfunction

   state_t           state, state_n;
   logic [PH_W-1:0]  phase, phase_n;
   logic [2:0]       core_rst_n, failed_n, vote_mask_n, clr_cnt;
   logic             sys_reset_n, recovering_n, degraded_n;
   logic [1:0]       recov_core_n, sel, n_persist;
   logic [CNT_W-1:0] retry [NUM_CORES];
   logic [CNT_W-1:0] retry_n [NUM_CORES];
   logic [2:0]       persist, ep;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_deb
      tmr_fault_debounce #(.PERSIST(PERSIST)) u_deb (
         .clk     (clk),
         .rst     (rst),
         .flag    (fault_flags[g]),
         .mask    (vote_mask[g]),
         .clear   (clr_cnt[g]),
         .persist (persist[g])
      );
   end

   // Only cores still taking part in the vote can raise a new fault
   assign ep        = persist & ~vote_mask;
   assign n_persist = {1'b0, ep[0]} + {1'b0, ep[1]} + {1'b0, ep[2]};
   assign retry_cnt = {retry[CORE_A], retry[CORE_B], retry[CORE_C]};

   // Priority pick of the single persisting core
   always_comb begin
      sel = 2'd0;
      if (ep[CORE_A]) begin
         sel = 2'd2;
      end else if (ep[CORE_B]) begin
         sel = 2'd1;
      end else begin
         sel = 2'd0;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      phase_n      = phase;
      core_rst_n   = core_rst;
      failed_n     = failed;
      retry_n      = retry;
      sys_reset_n  = sys_reset;
      recovering_n = recovering;
      recov_core_n = recov_core;
      clr_cnt      = 3'b000;
      case (state)
         ST_IDLE: begin
            if (clear_faults) begin
               failed_n   = 3'b000;
               core_rst_n = 3'b000;
               for (int i = 0; i < NUM_CORES; i++) begin
                  retry_n[i] = '0;
               end
            end else if ((n_persist >= 2'd2) || ((n_persist == 2'd1) && (|failed))) begin
               state_n     = ST_SYS_HOLD;
               core_rst_n  = 3'b111;
               sys_reset_n = 1'b1;
               phase_n     = HOLD_LD;
            end else if ((n_persist == 2'd1) && enable) begin
               if (retry[sel] < RETRY_LIM) begin
                  retry_n[sel]    = sat_inc(retry[sel]);
                  core_rst_n[sel] = 1'b1;
                  state_n         = ST_HOLD;
                  recovering_n    = 1'b1;
                  recov_core_n    = sel;
                  phase_n         = HOLD_LD;
               end else begin
                  failed_n[sel]   = 1'b1;
                  core_rst_n[sel] = 1'b1;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_HOLD, ST_RESYNC: begin
            if (|ep) begin
               // Second core fails mid-recovery: abandon it without a retry charge
               state_n      = ST_SYS_HOLD;
               core_rst_n   = 3'b111;
               sys_reset_n  = 1'b1;
               recovering_n = 1'b0;
               recov_core_n = 2'd0;
               phase_n      = HOLD_LD;
            end else if (phase != '0) begin
               phase_n = phase - PH_ONE;
            end else if (state == ST_HOLD) begin
               state_n    = ST_RESYNC;
               core_rst_n = failed;
               phase_n    = WAIT_LD;
            end else begin
               state_n      = ST_IDLE;
               recovering_n = 1'b0;
               recov_core_n = 2'd0;
               clr_cnt      = core_onehot(recov_core);
            end
         end
         ST_SYS_HOLD: begin
            if (phase != '0) begin
               phase_n = phase - PH_ONE;
            end else begin
               state_n    = ST_SYS_WAIT;
               core_rst_n = failed;
               phase_n    = WAIT_LD;
            end
         end
         ST_SYS_WAIT: begin
            if (phase != '0) begin
               phase_n = phase - PH_ONE;
            end else begin
               state_n     = ST_IDLE;
               sys_reset_n = 1'b0;
               clr_cnt     = 3'b111;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      vote_mask_n = failed_n | (recovering_n ? core_onehot(recov_core_n) : 3'b000);
      degraded_n  = |failed_n;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         phase      <= '0;
         core_rst   <= 3'b000;
         vote_mask  <= 3'b000;
         sys_reset  <= 1'b0;
         recovering <= 1'b0;
         recov_core <= 2'd0;
         failed     <= 3'b000;
         degraded   <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            retry[i] <= '0;
         end
      end else begin
         state      <= state_n;
         phase      <= phase_n;
         core_rst   <= core_rst_n;
         vote_mask  <= vote_mask_n;
         sys_reset  <= sys_reset_n;
         recovering <= recovering_n;
         recov_core <= recov_core_n;
         failed     <= failed_n;
         degraded   <= degraded_n;
         for (int i = 0; i < NUM_CORES; i++) begin
            retry[i] <= retry_n[i];
         end
      end
   end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl with PERSIST=4, RST_HOLD=8,
// RESYNC_WAIT=16, MAX_RETRY=2. Edge n = n-th clock edge after a test's stimulus starts.
module tb_tmr_recovery_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  fault_flags;
   logic        enable;
   logic        clear_faults;
   logic [2:0]  core_rst, vote_mask, failed;
   logic        sys_reset, recovering, degraded;
   logic [1:0]  recov_core;
   logic [11:0] retry_cnt;
   logic [9:0]  obs;
   int          total = 0;
   int          bad   = 0;

   tmr_recovery_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .fault_flags  (fault_flags),
      .enable       (enable),
      .clear_faults (clear_faults),
      .core_rst     (core_rst),
      .vote_mask    (vote_mask),
      .sys_reset    (sys_reset),
      .recovering   (recovering),
      .recov_core   (recov_core),
      .failed       (failed),
      .degraded     (degraded),
      .retry_cnt    (retry_cnt)
   );

   always #5 clk = ~clk;

   assign obs = {core_rst, vote_mask, sys_reset, recovering, recov_core};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      fault_flags  = 3'b000;
      enable       = 1'b1;
      clear_faults = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      total++;
      if (obs !== 10'd0) begin
         bad++;
         $display("FAIL reset_obs: got %b expected %b", obs, 10'd0);
      end
      total++;
      if ({failed, degraded, retry_cnt} !== 16'h0000) begin
         bad++;
         $display("FAIL reset_state: got %h expected %h", {failed, degraded, retry_cnt}, 16'h0000);
      end
   endtask

   task automatic test_single;
      logic [9:0] exp;
      do_reset;
      fault_flags = 3'b010;
      for (int e = 1; e <= 30; e++) begin
         tick;
         exp[9:7] = (e >= 5 && e <= 12) ? 3'b010 : 3'b000;
         exp[6:4] = (e >= 5 && e <= 28) ? 3'b010 : 3'b000;
         exp[3]   = 1'b0;
         exp[2]   = (e >= 5 && e <= 28);
         exp[1:0] = (e >= 5 && e <= 28) ? 2'd1 : 2'd0;
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL single e=%0d: got %b expected %b", e, obs, exp);
         end
         if (e == 5) fault_flags = 3'b000;
      end
      total++;
      if (retry_cnt !== 12'h010) begin
         bad++;
         $display("FAIL single_retry: got %h expected %h", retry_cnt, 12'h010);
      end
   endtask

   task automatic test_glitch;
      logic [2:0] pat [7];
      pat = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 3'b100, 3'b100};
      do_reset;
      for (int e = 1; e <= 12; e++) begin
         fault_flags = (e <= 7) ? pat[e-1] : 3'b000;
         tick;
         total++;
         if (obs !== 10'd0) begin
            bad++;
            $display("FAIL glitch e=%0d: got %b expected %b", e, obs, 10'd0);
         end
      end
   endtask

   task automatic test_retry_exhaust;
      do_reset;
      for (int r = 0; r < 3; r++) begin
         fault_flags = 3'b001;
         for (int e = 1; e <= 5; e++) tick;
         fault_flags = 3'b000;
         if (r < 2) begin
            total++;
            if ({obs, retry_cnt} !== {3'b001, 3'b001, 1'b0, 1'b1, 2'd0, 12'(r + 1)}) begin
               bad++;
               $display("FAIL retry_round%0d: got %h expected %h", r, {obs, retry_cnt},
                        {3'b001, 3'b001, 1'b0, 1'b1, 2'd0, 12'(r + 1)});
            end
            for (int e = 6; e <= 29; e++) tick;
            total++;
            if (obs !== 10'd0) begin
               bad++;
               $display("FAIL retry_idle%0d: got %b expected %b", r, obs, 10'd0);
            end
         end else begin
            total++;
            if ({obs, failed, degraded, retry_cnt} !== {10'b001_001_0_0_00, 3'b001, 1'b1, 12'h002}) begin
               bad++;
               $display("FAIL retry_failed: got %h expected %h", {obs, failed, degraded, retry_cnt},
                        {10'b001_001_0_0_00, 3'b001, 1'b1, 12'h002});
            end
         end
      end
      for (int e = 0; e < 5; e++) tick;
      total++;
      if (core_rst !== 3'b001) begin
         bad++;
         $display("FAIL retry_stuck: got %b expected %b", core_rst, 3'b001);
      end
      clear_faults = 1'b1;
      tick;
      clear_faults = 1'b0;
      total++;
      if ({obs, failed, degraded, retry_cnt} !== 26'd0) begin
         bad++;
         $display("FAIL retry_clear: got %h expected %h", {obs, failed, degraded, retry_cnt}, 26'd0);
      end
   endtask

   task automatic test_double;
      logic [5:0] exp;
      logic [5:0] got;
      do_reset;
      fault_flags = 3'b100;
      for (int e = 1; e <= 34; e++) begin
         tick;
         got      = {core_rst, sys_reset, recovering, vote_mask[2]};
         exp[5:3] = (e >= 5 && e <= 9) ? 3'b100 : (e >= 10 && e <= 17) ? 3'b111 : 3'b000;
         exp[2]   = (e >= 10 && e <= 33);
         exp[1]   = (e >= 5 && e <= 9);
         exp[0]   = (e >= 5 && e <= 9);
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL double e=%0d: got %b expected %b", e, got, exp);
         end
         if (e == 5) fault_flags = 3'b010;
         if (e == 9) fault_flags = 3'b000;
      end
      total++;
      if ({obs, retry_cnt} !== {10'd0, 12'h100}) begin
         bad++;
         $display("FAIL double_end: got %h expected %h", {obs, retry_cnt}, {10'd0, 12'h100});
      end
   endtask

   task automatic test_simultaneous;
      logic [9:0] exp;
      do_reset;
      fault_flags = 3'b101;
      for (int e = 1; e <= 30; e++) begin
         tick;
         exp      = 10'd0;
         exp[9:7] = (e >= 5 && e <= 12) ? 3'b111 : 3'b000;
         exp[3]   = (e >= 5 && e <= 28);
         total++;
         if ({obs, retry_cnt} !== {exp, 12'h000}) begin
            bad++;
            $display("FAIL simul e=%0d: got %h expected %h", e, {obs, retry_cnt}, {exp, 12'h000});
         end
         if (e == 5) fault_flags = 3'b000;
      end
   endtask

   task automatic test_reset_mid_hold;
      do_reset;
      fault_flags = 3'b010;
      for (int e = 1; e <= 7; e++) tick;
      fault_flags = 3'b000;
      total++;
      if (core_rst !== 3'b010) begin
         bad++;
         $display("FAIL midrst_hold: got %b expected %b", core_rst, 3'b010);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++;
      if ({obs, failed, degraded, retry_cnt} !== 26'd0) begin
         bad++;
         $display("FAIL midrst_clear: got %h expected %h", {obs, failed, degraded, retry_cnt}, 26'd0);
      end
      for (int e = 0; e < 6; e++) tick;
      total++;
      if (obs !== 10'd0) begin
         bad++;
         $display("FAIL midrst_idle: got %b expected %b", obs, 10'd0);
      end
   endtask

   task automatic test_enable_gate;
      do_reset;
      enable      = 1'b0;
      fault_flags = 3'b010;
      for (int e = 1; e <= 10; e++) begin
         tick;
         total++;
         if (obs !== 10'd0) begin
            bad++;
            $display("FAIL gate e=%0d: got %b expected %b", e, obs, 10'd0);
         end
      end
      enable = 1'b1;
      tick;
      fault_flags = 3'b000;
      total++;
      if ({obs, retry_cnt} !== {10'b010_010_0_1_01, 12'h010}) begin
         bad++;
         $display("FAIL gate_start: got %h expected %h", {obs, retry_cnt}, {10'b010_010_0_1_01, 12'h010});
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_glitch;
      test_retry_exhaust;
      test_double;
      test_simultaneous;
      test_reset_mid_hold;
      test_enable_gate;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tmr_recovery_ctrl.md
Name: tmr_recovery_ctrl

Overview:
Recovery scheduler for the triple-core MI-V TMR system. It consumes the triple_voter fault_flags and filters them for persistence. It then sequences per-core reset/resync of one faulty core at a time, masking that core from the vote while it recovers. It escalates to a whole-system reset on a double fault and retires a core permanently after repeated failures (degraded mode).

Parameters:
PERSIST, 4, consecutive fault cycles that make a core fault persistent (>=1)
RST_HOLD, 8, cycles core_rst is held high per recovery (>=1)
RESYNC_WAIT, 16, cycles after reset release that the core stays masked (>=1)
MAX_RETRY, 2, recoveries allowed per core before it is marked failed
CNT_W, 4, width of per-core retry counters (2**CNT_W > MAX_RETRY)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
fault_flags  in  3  voter per-core disagreement; [2]=A, [1]=B, [0]=C
enable  in  1  1 = new recoveries may start
clear_faults  in  1  pulse; clears failed[] and retry counts (IDLE only)
core_rst  out  3  per-core reset request, active-high, same bit map
vote_mask  out  3  1 = core excluded from voting
sys_reset  out  1  all-core reset in progress
recovering  out  1  single-core recovery in progress
recov_core  out  2  index of core in recovery (2=A,1=B,0=C); 0 when idle
failed  out  3  core permanently retired
degraded  out  1  |failed
retry_cnt  out  3*CNT_W  packed retry counts {A,B,C}

Behaviour:
- Reset (rst=1 at edge) sets all outputs, counters and state to 0 / IDLE. Reset mid-recovery aborts immediately; core_rst drops on the next cycle.
- Debounce, per core: cnt<=0 if the core is masked or its flag=0; else cnt<=min(cnt+1,PERSIST). persist_x = (cnt_x==PERSIST).
- Eligible core = not masked. vote_mask = failed | (recovering ? onehot(recov_core) : 0) | (sys_reset ? 3'b000 : 0).
- FSM states: IDLE, HOLD, RESYNC, SYS_HOLD, SYS_WAIT.
- IDLE transitions:
  - >=2 persist, or 1 persist while any failed bit set -> SYS_HOLD. This ignores enable.
  - Exactly 1 persist and enable=1 -> per that core:
    - retry<MAX_RETRY: retry++, core_rst[x]=1, go HOLD, recovering=1, recov_core=x.
    - Else: failed[x]=1, core_rst[x]=1 held permanently, stay IDLE.
  - Selection takes effect at the edge after persist is seen. With flag high from edge 1, core_rst rises after edge PERSIST+1.
- HOLD: core_rst[x] high exactly RST_HOLD cycles, then RESYNC. A persist on any other eligible core -> SYS_HOLD (double fault) immediately.
- RESYNC: core_rst[x]=0, still masked, RESYNC_WAIT cycles -> IDLE. Clear recovering and recov_core, and zero cnt_x. A double fault here also -> SYS_HOLD.
- SYS_HOLD:
  - core_rst=3'b111 and sys_reset=1 for RST_HOLD cycles, then SYS_WAIT for RESYNC_WAIT cycles with sys_reset=1 and core_rst=failed.
  - Exit to IDLE clears all debounce counters.
  - failed and retry counts are preserved. An in-progress single recovery is abandoned without further retry increment.
- Failed cores keep core_rst high and vote_mask high until clear_faults in IDLE. clear_faults in IDLE clears failed and retry counts next edge; it is ignored in any other state.
- enable=0 blocks only the start of single-core recovery. In-progress sequences and system escalation proceed.
- Retry counters saturate at 2**CNT_W-1.
- Phase counter is one shared down-counter of width clog2(max(RST_HOLD,RESYNC_WAIT)+1).

Decomposition:
- tmr_pkg holds:
  - the FSM state enum;
  - core index constants CORE_A=2, CORE_B=1, CORE_C=0;
  - the NUM_CORES=3 constant.
- Natural sub-module: tmr_fault_debounce (one core's persistence counter with mask/clear inputs), instantiated 3x.

Test Plan (PERSIST=4, RST_HOLD=8, RESYNC_WAIT=16, MAX_RETRY=2):
1. Single persistent fault:
   - Stimulus: fault_flags=3'b010 held from edge 1.
   - Response: core_rst=3'b010 after edge 5, high 8 cycles. vote_mask[1]=1 for 24 cycles. retry_cnt B=1. Then IDLE, all 0.
2. Glitch rejection:
   - Stimulus: fault_flags[2] high 3 cycles, low 1, high 3.
   - Response: no core_rst, state stays IDLE.
3. Retry exhaustion:
   - Stimulus: core C faults persistently three times, each after full recovery.
   - Response: retries 1,2, then failed=3'b001, degraded=1, core_rst[0] stuck high. clear_faults pulse in IDLE -> failed=0, retry_cnt=0.
4. Double fault:
   - Stimulus: A in HOLD, then fault_flags[1] high 4 cycles.
   - Response: sys_reset=1, core_rst=3'b111 for 8 cycles, then 16-cycle wait. IDLE with retry A preserved.
5. Simultaneous persist:
   - Stimulus: fault_flags=3'b101 from edge 1.
   - Response: SYS_HOLD after edge 5. No retry increment.
6. Reset mid-HOLD:
   - Stimulus: rst=1 at cycle 3 of HOLD.
   - Response: all outputs 0 the next cycle; retry_cnt=0.
7. enable=0 gating:
   - Stimulus: enable=0 with persistent B fault.
   - Response: no recovery starts. Raise enable -> recovery starts the next edge.
